mem_port_arbiter: RTL and testbench

Sequencing controller placed in front of the byte-addressable single-port `Memory` (32-bit, 4-byte access at ADDR..ADDR+3, combinational read, posedge write). It shares the port between an instruction-fetch requester and a data requester using round-robin arbitration. It applies RV32 load/store sizing: sign/zero extension for loads, and read-modify-write for byte/halfword stores, because the memory always writes 4 bytes. All accesses are multi-cycle, with a req/ack handshake per requester.

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-addressable memory port between
// instruction fetch and RV32 data accesses (load extension, SB/SH merge).
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_funct3,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    MERGE,
    ACCESS,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  lg_d_q, lg_d_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] merge_q, merge_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  pick_d;
  logic                  sub_word;

  function automatic logic [DATA_WIDTH-1:0] ext(
    input logic [2:0]            f3,
    input logic [DATA_WIDTH-1:0] rd
  );
    logic [DATA_WIDTH-1:0] r;
    r = rd;
    unique case (f3)
      3'b000: r = {{(DATA_WIDTH-8){rd[7]}}, rd[7:0]};
      3'b001: r = {{(DATA_WIDTH-16){rd[15]}}, rd[15:0]};
      3'b100: r = {{(DATA_WIDTH-8){1'b0}}, rd[7:0]};
      3'b101: r = {{(DATA_WIDTH-16){1'b0}}, rd[15:0]};
      default: r = rd;
    endcase
    return r;
  endfunction

  // lg_d_q doubles as the current owner once a grant is made
  assign sub_word = we_q && (f3_q[2:1] == 2'b00);
  assign busy     = (state_q != IDLE);
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

  always_comb begin
    state_d   = state_q;
    lg_d_d    = lg_d_q;
    addr_d    = addr_q;
    we_d      = we_q;
    f3_d      = f3_q;
    wdata_d   = wdata_q;
    merge_d   = merge_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    pick_d    = 1'b0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wd    = '0;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          pick_d  = d_req && (!i_req || !lg_d_q);
          lg_d_d  = pick_d;
          addr_d  = pick_d ? d_addr : i_addr;
          we_d    = pick_d && d_we;
          f3_d    = pick_d ? d_funct3 : 3'b010;
          wdata_d = pick_d ? d_wdata : '0;
          if (pick_d && d_we && d_funct3[2:1] == 2'b00)
            state_d = MERGE;
          else
            state_d = ACCESS;
        end
      end
      MERGE: begin
        mem_addr      = addr_q;
        merge_d       = mem_rd;
        merge_d[7:0]  = wdata_q[7:0];
        if (f3_q[0])
          merge_d[15:8] = wdata_q[15:8];
        state_d = ACCESS;
      end
      ACCESS: begin
        mem_addr = addr_q;
        if (we_q) begin
          mem_we = 1'b1;
          mem_wd = sub_word ? merge_q : wdata_q;
        end else if (lg_d_q) begin
          d_rdata_d = ext(f3_q, mem_rd);
        end else begin
          i_rdata_d = ext(f3_q, mem_rd);
        end
        state_d = RESP;
      end
      RESP: begin
        i_ack   = !lg_d_q;
        d_ack   = lg_d_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lg_d_q    <= 1'b1;
      addr_q    <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      wdata_q   <= '0;
      merge_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      lg_d_q    <= lg_d_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      wdata_q   <= wdata_d;
      merge_q   <= merge_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte memory model plus transaction-level
// reference memory; directed cases then randomized fetch/load/store traffic.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [2:0]  d_funct3;
  logic        i_ack, d_ack, mem_we, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wd, mem_rd;

  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;

  logic [7:0]  mem [0:255];
  logic [7:0]  ref_mem [0:255];
  logic [7:0]  ma;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_last_d;
  logic [31:0] exp_last_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .busy(busy)
  );

  assign ma = mem_addr[7:0];
  assign mem_rd = {mem[8'(ma + 8'd3)], mem[8'(ma + 8'd2)],
                   mem[8'(ma + 8'd1)], mem[ma]};

  always @(posedge clk) begin
    if (bd_we) begin
      for (int k = 0; k < 4; k++)
        mem[8'(bd_addr + 8'(k))] <= bd_data[8*k +: 8];
    end else if (mem_we) begin
      for (int k = 0; k < 4; k++)
        mem[8'(ma + 8'(k))] <= mem_wd[8*k +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    return {ref_mem[8'(a + 8'd3)], ref_mem[8'(a + 8'd2)],
            ref_mem[8'(a + 8'd1)], ref_mem[a]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)],
            mem[8'(a + 8'd1)], mem[a]};
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3,
                                             input logic [7:0] a);
    logic [31:0] w, b, h;
    w = ref_word(a);
    b = w % 256;
    h = w % 65536;
    case (f3)
      3'd0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [7:0] a,
                             input logic [31:0] wd);
    int n;
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int k = 0; k < n; k++)
      ref_mem[8'(a + 8'(k))] = wd[8*k +: 8];
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [31:0] w);
    bd_we = 1'b1; bd_addr = a; bd_data = w;
    @(negedge clk);
    bd_we = 1'b0;
    for (int k = 0; k < 4; k++)
      ref_mem[8'(a + 8'(k))] = w[8*k +: 8];
  endtask

  task automatic i_txn(input logic [31:0] a, input logic [31:0] exp_rd);
    int n;
    bit got, saw_we;
    i_req = 1'b1; i_addr = a;
    n = 0; got = 0; saw_we = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (mem_we) saw_we = 1;
      if (i_ack) got = 1;
    end
    chk("i_lat", got ? 32'(n) : 32'hFFFFFFFF, 32'd2);
    chk("i_rdata", i_rdata, exp_rd);
    chk("i_no_we", 32'(saw_we), 32'd0);
    chk("i_d_hold", d_rdata, exp_last_d);
    exp_last_i = exp_rd;
    i_req = 1'b0;
    @(negedge clk);
    chk("i_ack_pulse", 32'(i_ack), 32'd0);
  endtask

  task automatic d_txn(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int exp_lat, input logic [31:0] exp_rd);
    int n;
    bit got;
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
    n = 0; got = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (d_ack) got = 1;
    end
    chk("d_lat", got ? 32'(n) : 32'hFFFFFFFF, 32'(exp_lat));
    if (!we) exp_last_d = exp_rd;
    chk(we ? "d_rdata_hold" : "d_rdata", d_rdata, exp_last_d);
    chk("d_i_hold", i_rdata, exp_last_i);
    d_req = 1'b0;
    @(negedge clk);
    chk("d_ack_pulse", 32'(d_ack), 32'd0);
  endtask

  initial begin
    logic [31:0] a, wd, e;
    logic [2:0]  f3;
    logic        we;
    int          seq[$];
    int          n;

    rst = 1'b1;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0;
    d_funct3 = 0; d_addr = 0; d_wdata = 0;
    bd_we = 0; bd_addr = 0; bd_data = 0;
    exp_last_d = 0; exp_last_i = 0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    for (int w = 0; w < 64; w++) begin
      @(negedge clk);
      bd_write(8'(4 * w), $urandom);
    end
    bd_write(8'h10, 32'hDEADBEEF);
    bd_write(8'h20, 32'h11223344);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    i_txn(32'h10, 32'hDEADBEEF);
    d_txn(0, 3'b000, 32'h10, 0, 2, 32'hFFFFFFEF);
    d_txn(0, 3'b100, 32'h10, 0, 2, 32'h000000EF);
    d_txn(0, 3'b001, 32'h10, 0, 2, 32'hFFFFBEEF);
    d_txn(0, 3'b101, 32'h10, 0, 2, 32'h0000BEEF);
    d_txn(0, 3'b010, 32'h10, 0, 2, 32'hDEADBEEF);

    d_txn(1, 3'b000, 32'h20, 32'hAABBCCDD, 3, 0);
    model_store(3'b000, 8'h20, 32'hAABBCCDD);
    d_txn(0, 3'b010, 32'h20, 0, 2, 32'h112233DD);
    bd_write(8'h20, 32'h11223344);
    d_txn(1, 3'b001, 32'h20, 32'hAABBCCDD, 3, 0);
    model_store(3'b001, 8'h20, 32'hAABBCCDD);
    d_txn(0, 3'b010, 32'h20, 0, 2, 32'h1122CCDD);
    d_txn(1, 3'b010, 32'h24, 32'h01020304, 2, 0);
    model_store(3'b010, 8'h24, 32'h01020304);
    chk("sw_mem", mem_word(8'h24), 32'h01020304);

    // both requesters held from reset: grants must alternate
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_last_d = 0; exp_last_i = 0;
    i_req = 1; i_addr = 32'h10;
    d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 32'h20;
    n = 0;
    while (seq.size() < 4 && n < 20) begin
      @(negedge clk);
      n++;
      if (i_ack) seq.push_back(1);
      if (d_ack) seq.push_back(2);
    end
    i_req = 0; d_req = 0;
    chk("arb_count", 32'(seq.size()), 32'd4);
    while (seq.size() < 4) seq.push_back(0);
    chk("arb_g0", 32'(seq[0]), 32'd1);
    chk("arb_g1", 32'(seq[1]), 32'd2);
    chk("arb_g2", 32'(seq[2]), 32'd1);
    chk("arb_g3", 32'(seq[3]), 32'd2);
    exp_last_d = 32'h1122CCDD; exp_last_i = 32'hDEADBEEF;
    @(negedge clk);

    // reset while a word store is in ACCESS
    d_req = 1; d_we = 1; d_funct3 = 3'b010;
    d_addr = 32'h30; d_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("acc_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_we", 32'(mem_we), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_bus", mem_addr | mem_wd, 32'd0);
    chk("mid_rdata", i_rdata | d_rdata, 32'd0);
    chk("mid_acks", {30'd0, i_ack, d_ack}, 32'd0);
    d_req = 0;
    @(negedge clk);
    rst = 1'b0;
    exp_last_d = 0; exp_last_i = 0;
    @(negedge clk);
    chk("post_busy", 32'(busy), 32'd0);
    chk("abort_sw_mem", mem_word(8'h30), ref_word(8'h30));

    // reset while an SB sits in MERGE
    bd_write(8'h20, 32'h11223344);
    d_req = 1; d_we = 1; d_funct3 = 3'b000;
    d_addr = 32'h20; d_wdata = 32'hAABBCCDD;
    @(negedge clk);
    chk("merge_busy", 32'(busy), 32'd1);
    chk("merge_we", 32'(mem_we), 32'd0);
    rst = 1'b1;
    #1;
    chk("mrst_we", 32'(mem_we), 32'd0);
    d_req = 0;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (d_ack || mem_we) n++;
    end
    chk("mrst_no_ack", 32'(n), 32'd0);
    chk("mrst_mem", mem_word(8'h20), 32'h11223344);

    for (int it = 0; it < 60; it++) begin
      a = 32'h40 + $urandom_range(0, 59);
      if ($urandom_range(0, 3) == 0) begin
        i_txn(a, ref_word(a[7:0]));
      end else begin
        we = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        wd = $urandom;
        if (we) begin
          d_txn(1, f3, a, wd, (f3 == 3'd0 || f3 == 3'd1) ? 3 : 2, 0);
          model_store(f3, a[7:0], wd);
          chk("rnd_mem", mem_word(a[7:0]), ref_word(a[7:0]));
        end else begin
          e = model_load(f3, a[7:0]);
          d_txn(0, f3, a, 0, 2, e);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
